stp_sr_tx_ctrl: RTL and testbench
=================================

# stp_sr_tx_ctrl

Transmit-direction datapath for the I2C slave: loads a byte from the slave controller, drives it MSB-first onto SDA on SCL falling edges, releases SDA for the master's ACK bit, and reports ACK/NACK. It sits beside the slave RX shift register, consumes the same synchronized SCL edge strobes, and feeds the open-drain SDA output mux. It also owns the bit counter and the per-byte transmit state machine.

## Interface
- No parameters. Byte width is fixed at 8 via package constant.
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- SDA_sync  in  1  synchronized SDA line
- rising_edge  in  1  one-cycle strobe, synchronized SCL rising edge
- falling_edge  in  1  one-cycle strobe, synchronized SCL falling edge
- tx_enable  in  1  level; slave is in transmit (read) mode
- load_data  in  1  one-cycle strobe; capture tx_data and begin a byte
- abort  in  1  start or stop detected; cancel immediately
- tx_data  in  8  byte to send
- sda_out  out  1  SDA drive; 0 pulls low, 1 releases
- tx_busy  out  1  byte in progress (any state except IDLE)
- ack_done  out  1  one-cycle pulse when the ACK bit is sampled
- ack_received  out  1  latched result; 1 means ACK (SDA low) was sampled
- byte_done  out  1  one-cycle pulse at the falling edge that ends the ACK clock

## Operation
- States: IDLE, SHIFT, ACK_WAIT, ACK_HOLD, plus WAIT_LOAD when configured.
- IDLE: sda_out=1. On load_data with tx_enable=1 and abort=0:
  - capture tx_data into the shift register
  - set bit_cnt=0
  - go to SHIFT
- load_data in any non-IDLE state, or with tx_enable=0: ignored.
- SHIFT: sda_out = shift register MSB. On falling_edge:
  - if bit_cnt==7, go to ACK_WAIT.
  - else shift left (LSB fill 1) and increment bit_cnt.
- ACK_WAIT: sda_out=1. On rising_edge:
  - latch ack_received = ~SDA_sync
  - pulse ack_done
  - go to ACK_HOLD
- ACK_HOLD: sda_out=1. On falling_edge, pulse byte_done, then:
  - go to WAIT_LOAD if configured and ack_received=1 and tx_enable=1
  - otherwise go to IDLE
- abort=1 or tx_enable=0 in any state:
  - next state IDLE, sda_out=1 on the next cycle
  - no ack_done or byte_done pulse
  - ack_received unchanged
  - abort wins over a simultaneous load_data or edge strobe.
- rising_edge and falling_edge are mutually exclusive by construction; if both are seen, falling_edge is processed and rising_edge is dropped.
- ack_received is cleared on each accepted load_data.

## Timing
- Reset values: state IDLE, sda_out=1, tx_busy=0, ack_done=0, ack_received=0, byte_done=0, bit_cnt=0, shift register 0xFF.
- All outputs are registered.
- sda_out shows the MSB on the cycle after load_data. The controller issues load_data while SCL is low, i.e. after the address/previous ACK falling edge.
- Each bit change appears one cycle after its falling_edge strobe. SDA therefore never changes on a rising_edge.
- ack_done occurs one cycle after the 9th rising_edge. byte_done occurs one cycle after the 9th falling_edge.
- Back-to-back bytes: load_data is legal the cycle after byte_done.

## Configuration
- Macro: I2C_SLAVE_TX_STRETCH_EN.
- Defined:
  - adds output scl_hold (1 bit, reset 0) and state WAIT_LOAD.
  - In WAIT_LOAD: scl_hold=1, sda_out=1, tx_busy=1.
  - load_data goes to SHIFT with scl_hold deasserting the same cycle sda_out presents the MSB.
  - abort or tx_enable=0 goes to IDLE with scl_hold=0.
- Undefined: no scl_hold port, no WAIT_LOAD. ACK_HOLD always returns to IDLE, and the controller must supply data before the master's next rising edge.

## Structure
- Shared package i2c_slave_pkg holds:
  - I2C_BYTE_W = 8
  - the tx state enum (IDLE, SHIFT, ACK_WAIT, ACK_HOLD, WAIT_LOAD)
- One sub-module: flex_pts_sr (parallel-to-serial, MSB first, width 8, shift value 1) instantiated as the shift register.
- Counter and FSM stay local.

## Test plan
- Load 0xA5, apply 8 falling_edge/rising_edge pairs. Expect sda_out sequence 1,0,1,0,0,1,0,1, stable across every rising_edge, then sda_out=1 after the 8th falling_edge.
- After a 0x3C byte, hold SDA_sync=0 at the 9th rising_edge. Expect ack_done pulse, ack_received=1, byte_done one cycle after the 9th falling_edge, then IDLE.
- Same byte, SDA_sync=1 at the 9th rising_edge. Expect ack_received=0, byte_done, IDLE; with the macro defined, scl_hold stays 0.
- Assert abort after bit 3 of 0x00. Expect sda_out=1 and tx_busy=0 the next cycle, no ack_done or byte_done, and a subsequent load of 0xFF transmits correctly.
- Assert load_data mid-byte with tx_data=0x12. The current byte continues unchanged. Assert load_data with tx_enable=0. The block stays IDLE.
- With I2C_SLAVE_TX_STRETCH_EN: after an ACK, scl_hold=1 until load_data (0x81). The MSB drives 1 the cycle scl_hold falls. An async n_rst mid-WAIT_LOAD returns all outputs to reset values.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared I2C slave types and constants: byte width, bit counter width and the
// transmit state encoding used by the TX controller.
// Pure declarations, no logic; no latency or backpressure of its own.
package i2c_slave_pkg;

   localparam int I2C_BYTE_W = 8;
   localparam int I2C_CNT_W  = $clog2(I2C_BYTE_W);

   // Last bit index of a byte, in counter width.
   localparam logic [I2C_CNT_W-1:0] I2C_LAST_BIT = I2C_CNT_W'(I2C_BYTE_W - 1);

   // WAIT_LOAD is only reachable when clock stretching is built in.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT     = 3'd1,
      ACK_WAIT  = 3'd2,
      ACK_HOLD  = 3'd3,
      WAIT_LOAD = 3'd4
   } tx_state_t;

endpackage : i2c_slave_pkg

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register, MSB first, vacated LSBs filled with FILL_VAL.
// Latency: load/shift take effect on the next clk edge; msb_next shows that value now.
// Backpressure: none; load_enable has priority over shift_enable.
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset (register resets to all ones)
//   load_enable       capture parallel_in
//   shift_enable      shift left by one, LSB <= FILL_VAL
//   parallel_in       word to load
//   msb_next          MSB the register will hold after this cycle's edge
module flex_pts_sr
   import i2c_slave_pkg::*;
#(
   parameter int   NUM_BITS = I2C_BYTE_W,
   parameter logic FILL_VAL = 1'b1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                load_enable,
   input  logic                shift_enable,
   input  logic [NUM_BITS-1:0] parallel_in,
   output logic                msb_next
);

   logic [NUM_BITS-1:0] data_q;
   logic [NUM_BITS-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load_enable) begin
         data_d = parallel_in;
      end else if (shift_enable) begin
         data_d = {data_q[NUM_BITS-2:0], FILL_VAL};
      end
   end

   // Exposing the next MSB lets the owner register SDA in the same cycle
   // the register updates, so the line never lags the shift by a cycle.
   assign msb_next = data_d[NUM_BITS-1];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_q <= '1;
      end else begin
         data_q <= data_d;
      end
   end

endmodule : flex_pts_sr

// File: rtl/stp_sr_tx_ctrl.sv
// I2C slave transmit controller: shifts a byte MSB-first onto SDA on SCL falls, samples master ACK.
// Latency: every output is registered and moves one cycle after the strobe that causes it.
// Backpressure: load_data accepted only in IDLE (or WAIT_LOAD); abort / tx_enable low cancel at once.
//
// Optional feature: define I2C_SLAVE_TX_STRETCH_EN to add scl_hold and the WAIT_LOAD state,
// which stretches SCL after an ACKed byte until the next load_data arrives.
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   SDA_sync                    synchronized SDA (sampled for the master ACK)
//   rising_edge, falling_edge   one-cycle synchronized SCL edge strobes
//   tx_enable, load_data, abort mode level, byte load strobe, start/stop cancel
//   tx_data                     byte to send
//   sda_out                     SDA drive (0 pulls low, 1 releases)
//   tx_busy                     any state other than IDLE
//   ack_done, byte_done         one-cycle pulses: ACK sampled, ACK clock finished
//   ack_received                1 when the last sampled ACK bit was low
//   scl_hold                    (stretch build only) hold SCL low while waiting for data
module stp_sr_tx_ctrl
   import i2c_slave_pkg::*;
(
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  SDA_sync,
   input  logic                  rising_edge,
   input  logic                  falling_edge,
   input  logic                  tx_enable,
   input  logic                  load_data,
   input  logic                  abort,
   input  logic [I2C_BYTE_W-1:0] tx_data,
   output logic                  sda_out,
   output logic                  tx_busy,
   output logic                  ack_done,
   output logic                  ack_received,
   output logic                  byte_done
`ifdef I2C_SLAVE_TX_STRETCH_EN
   ,
   output logic                  scl_hold
`endif
);

   tx_state_t            state_q, state_d;
   logic [I2C_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 sda_out_q, sda_out_d;
   logic                 tx_busy_q, tx_busy_d;
   logic                 ack_done_q, ack_done_d;
   logic                 ack_received_q, ack_received_d;
   logic                 byte_done_q, byte_done_d;
   logic                 sr_load;
   logic                 sr_shift;
   logic                 sr_msb_next;
   logic                 rise_ok;
`ifdef I2C_SLAVE_TX_STRETCH_EN
   logic                 scl_hold_q, scl_hold_d;
`endif

   flex_pts_sr #(
      .NUM_BITS (I2C_BYTE_W),
      .FILL_VAL (1'b1)
   ) u_pts_sr (
      .clk          (clk),
      .n_rst        (n_rst),
      .load_enable  (sr_load),
      .shift_enable (sr_shift),
      .parallel_in  (tx_data),
      .msb_next     (sr_msb_next)
   );

   // The two strobes cannot legally coincide; if they do, the fall is
   // honoured and the rise is dropped.
   assign rise_ok = rising_edge & ~falling_edge;

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      ack_received_d = ack_received_q;
      ack_done_d     = 1'b0;
      byte_done_d    = 1'b0;
      sr_load        = 1'b0;
      sr_shift       = 1'b0;

      if (abort || !tx_enable) begin
         // Cancel wins over everything, including a same-cycle load or edge.
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (load_data) begin
                  sr_load        = 1'b1;
                  bit_cnt_d      = '0;
                  ack_received_d = 1'b0;
                  state_d        = SHIFT;
               end
            end
            SHIFT: begin
               if (falling_edge) begin
                  if (bit_cnt_q == I2C_LAST_BIT) begin
                     state_d = ACK_WAIT;
                  end else begin
                     sr_shift  = 1'b1;
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            ACK_WAIT: begin
               if (rise_ok) begin
                  ack_received_d = ~SDA_sync;
                  ack_done_d     = 1'b1;
                  state_d        = ACK_HOLD;
               end
            end
            ACK_HOLD: begin
               if (falling_edge) begin
                  byte_done_d = 1'b1;
`ifdef I2C_SLAVE_TX_STRETCH_EN
                  // tx_enable is known high here; only an ACK keeps the transfer going.
                  state_d = ack_received_q ? WAIT_LOAD : IDLE;
`else
                  state_d = IDLE;
`endif
               end
            end
`ifdef I2C_SLAVE_TX_STRETCH_EN
            WAIT_LOAD: begin
               if (load_data) begin
                  sr_load        = 1'b1;
                  bit_cnt_d      = '0;
                  ack_received_d = 1'b0;
                  state_d        = SHIFT;
               end
            end
`endif
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // Outputs are decoded from the next state so they register alongside it;
      // SDA only moves on a load or a falling-edge shift, never on a rise.
      sda_out_d = (state_d == SHIFT) ? sr_msb_next : 1'b1;
      tx_busy_d = (state_d != IDLE);
`ifdef I2C_SLAVE_TX_STRETCH_EN
      scl_hold_d = (state_d == WAIT_LOAD);
`endif
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         sda_out_q      <= 1'b1;
         tx_busy_q      <= 1'b0;
         ack_done_q     <= 1'b0;
         ack_received_q <= 1'b0;
         byte_done_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         sda_out_q      <= sda_out_d;
         tx_busy_q      <= tx_busy_d;
         ack_done_q     <= ack_done_d;
         ack_received_q <= ack_received_d;
         byte_done_q    <= byte_done_d;
      end
   end

`ifdef I2C_SLAVE_TX_STRETCH_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_hold_q <= 1'b0;
      end else begin
         scl_hold_q <= scl_hold_d;
      end
   end

   assign scl_hold = scl_hold_q;
`endif

   assign sda_out      = sda_out_q;
   assign tx_busy      = tx_busy_q;
   assign ack_done     = ack_done_q;
   assign ack_received = ack_received_q;
   assign byte_done    = byte_done_q;

endmodule : stp_sr_tx_ctrl

// File: tb/tb_stp_sr_tx_ctrl.sv
// Directed bench for stp_sr_tx_ctrl: vector table for one full byte, plus
// hand-written sequences for ACK/NACK, back-to-back load, abort and stretching.
// Build with I2C_SLAVE_TX_STRETCH_EN defined to cover the scl_hold path too.
module tb_stp_sr_tx_ctrl;

   logic       clk;
   logic       n_rst;
   logic       sdi;
   logic       re;
   logic       fe;
   logic       en;
   logic       ld;
   logic       ab;
   logic [7:0] dat;
   logic       sda_out;
   logic       tx_busy;
   logic       ack_done;
   logic       ack_received;
   logic       byte_done;
`ifdef I2C_SLAVE_TX_STRETCH_EN
   logic       scl_hold;
   localparam logic STRETCH = 1'b1;
`else
   localparam logic STRETCH = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   stp_sr_tx_ctrl dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .SDA_sync     (sdi),
      .rising_edge  (re),
      .falling_edge (fe),
      .tx_enable    (en),
      .load_data    (ld),
      .abort        (ab),
      .tx_data      (dat),
      .sda_out      (sda_out),
      .tx_busy      (tx_busy),
      .ack_done     (ack_done),
      .ack_received (ack_received),
      .byte_done    (byte_done)
`ifdef I2C_SLAVE_TX_STRETCH_EN
      ,
      .scl_hold     (scl_hold)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in  = {load_data, tx_enable, abort, falling_edge, rising_edge, SDA_sync}
   // exp = {sda_out, tx_busy, ack_done, ack_received, byte_done}
   typedef struct {
      logic [5:0] in;
      logic [7:0] dat;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mkv(input logic [5:0] i, input logic [7:0] d, input logic [4:0] e);
      vec_t v;
      v.in  = i;
      v.dat = d;
      v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic l, input logic f, input logic r, input logic a, input logic [7:0] d);
      ld  = l;
      fe  = f;
      re  = r;
      ab  = a;
      dat = d;
      @(posedge clk);
      #1;
      ld = 1'b0;
      fe = 1'b0;
      re = 1'b0;
      ab = 1'b0;
   endtask

   // Bits first..last of d: SDA must hold across the rise and advance on the fall.
   task automatic send_bits(input logic [7:0] d, input int first, input int last, input string tag);
      logic e;
      for (int i = first; i <= last; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
         chk($sformatf("%s rise%0d sda", tag, i), {7'd0, sda_out}, {7'd0, d[7-i]});
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         if (i < 7) e = d[6-i];
         else e = 1'b1;
         chk($sformatf("%s fall%0d sda", tag, i), {7'd0, sda_out}, {7'd0, e});
         chk($sformatf("%s fall%0d busy", tag, i), {7'd0, tx_busy}, 8'd1);
      end
   endtask

   // 9th clock: ACK sampled on the rise, byte_done on the fall.
   task automatic ack_phase(input logic s, input logic exp_ack, input logic exp_busy, input string tag);
      sdi = s;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk({tag, " ack_done"}, {7'd0, ack_done}, 8'd1);
      chk({tag, " ack_received"}, {7'd0, ack_received}, {7'd0, exp_ack});
      chk({tag, " ack sda"}, {7'd0, sda_out}, 8'd1);
      sdi = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk({tag, " ack_done end"}, {7'd0, ack_done}, 8'd0);
      chk({tag, " early byte_done"}, {7'd0, byte_done}, 8'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk({tag, " byte_done"}, {7'd0, byte_done}, 8'd1);
      chk({tag, " busy after"}, {7'd0, tx_busy}, {7'd0, exp_busy});
   endtask

   initial begin
      n_rst = 1'b0;
      sdi   = 1'b1;
      re    = 1'b0;
      fe    = 1'b0;
      en    = 1'b1;
      ld    = 1'b0;
      ab    = 1'b0;
      dat   = 8'h00;

      tbl[0]  = mkv(6'b110001, 8'hA5, 5'b11000);
      tbl[1]  = mkv(6'b010011, 8'h00, 5'b11000);
      tbl[2]  = mkv(6'b010101, 8'h00, 5'b01000);
      tbl[3]  = mkv(6'b010011, 8'h00, 5'b01000);
      tbl[4]  = mkv(6'b010101, 8'h00, 5'b11000);
      tbl[5]  = mkv(6'b010011, 8'h00, 5'b11000);
      tbl[6]  = mkv(6'b010101, 8'h00, 5'b01000);
      tbl[7]  = mkv(6'b010011, 8'h00, 5'b01000);
      tbl[8]  = mkv(6'b010101, 8'h00, 5'b01000);
      tbl[9]  = mkv(6'b010011, 8'h00, 5'b01000);
      tbl[10] = mkv(6'b010101, 8'h00, 5'b11000);
      tbl[11] = mkv(6'b010011, 8'h00, 5'b11000);
      tbl[12] = mkv(6'b010101, 8'h00, 5'b01000);
      tbl[13] = mkv(6'b010011, 8'h00, 5'b01000);
      tbl[14] = mkv(6'b010101, 8'h00, 5'b11000);
      tbl[15] = mkv(6'b010011, 8'h00, 5'b11000);
      tbl[16] = mkv(6'b010101, 8'h00, 5'b11000);
      tbl[17] = mkv(6'b010001, 8'h00, 5'b11000);
      tbl[18] = mkv(6'b010011, 8'h00, 5'b11100);
      tbl[19] = mkv(6'b010001, 8'h00, 5'b11000);
      tbl[20] = mkv(6'b010101, 8'h00, 5'b10001);
      tbl[21] = mkv(6'b010001, 8'h00, 5'b10000);
      tbl[22] = mkv(6'b100001, 8'h12, 5'b10000);
      tbl[23] = mkv(6'b111001, 8'h12, 5'b10000);
      tbl[24] = mkv(6'b010111, 8'h00, 5'b10000);

      // Reset values (asynchronous, checked before any clock edge releases it).
      #12;
      chk("rst sda_out", {7'd0, sda_out}, 8'd1);
      chk("rst tx_busy", {7'd0, tx_busy}, 8'd0);
      chk("rst ack_done", {7'd0, ack_done}, 8'd0);
      chk("rst ack_received", {7'd0, ack_received}, 8'd0);
      chk("rst byte_done", {7'd0, byte_done}, 8'd0);
`ifdef I2C_SLAVE_TX_STRETCH_EN
      chk("rst scl_hold", {7'd0, scl_hold}, 8'd0);
`endif
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // Byte 0xA5 with NACK, then ignored loads and a coincident-strobe cycle in IDLE.
      for (int i = 0; i < 25; i++) begin
         ld  = tbl[i].in[5];
         en  = tbl[i].in[4];
         ab  = tbl[i].in[3];
         fe  = tbl[i].in[2];
         re  = tbl[i].in[1];
         sdi = tbl[i].in[0];
         dat = tbl[i].dat;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d sda_out", i), {7'd0, sda_out}, {7'd0, tbl[i].exp[4]});
         chk($sformatf("vec%0d tx_busy", i), {7'd0, tx_busy}, {7'd0, tbl[i].exp[3]});
         chk($sformatf("vec%0d ack_done", i), {7'd0, ack_done}, {7'd0, tbl[i].exp[2]});
         chk($sformatf("vec%0d ack_received", i), {7'd0, ack_received}, {7'd0, tbl[i].exp[1]});
         chk($sformatf("vec%0d byte_done", i), {7'd0, byte_done}, {7'd0, tbl[i].exp[0]});
      end
      ld  = 1'b0;
      en  = 1'b1;
      ab  = 1'b0;
      fe  = 1'b0;
      re  = 1'b0;
      sdi = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // 0x3C with ACK, back-to-back reload the cycle after byte_done, then 0x3C with NACK.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
      chk("3c msb", {7'd0, sda_out}, 8'd0);
      send_bits(8'h3C, 0, 7, "3c_ack");
      ack_phase(1'b0, 1'b1, STRETCH, "3c_ack");
`ifdef I2C_SLAVE_TX_STRETCH_EN
      chk("3c_ack scl_hold", {7'd0, scl_hold}, 8'd1);
`endif
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
      chk("b2b busy", {7'd0, tx_busy}, 8'd1);
      chk("b2b msb", {7'd0, sda_out}, 8'd0);
      chk("b2b ack cleared", {7'd0, ack_received}, 8'd0);
      chk("b2b byte_done end", {7'd0, byte_done}, 8'd0);
      send_bits(8'h3C, 0, 7, "3c_nack");
      ack_phase(1'b1, 1'b0, 1'b0, "3c_nack");
`ifdef I2C_SLAVE_TX_STRETCH_EN
      chk("3c_nack scl_hold", {7'd0, scl_hold}, 8'd0);
`endif
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("3c_nack idle busy", {7'd0, tx_busy}, 8'd0);
      chk("3c_nack byte_done end", {7'd0, byte_done}, 8'd0);

      // A load mid-byte must not disturb the byte in flight.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
      send_bits(8'hC3, 0, 1, "c3");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
      chk("midload sda", {7'd0, sda_out}, 8'd0);
      chk("midload busy", {7'd0, tx_busy}, 8'd1);
      send_bits(8'hC3, 2, 7, "c3");
      ack_phase(1'b1, 1'b0, 1'b0, "c3");

      // Abort after bit 3 of 0x00: immediate release, no pulses afterwards.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      send_bits(8'h00, 0, 2, "abort");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("abort sda", {7'd0, sda_out}, 8'd1);
      chk("abort busy", {7'd0, tx_busy}, 8'd0);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
         chk($sformatf("post-abort rise%0d ack_done", i), {7'd0, ack_done}, 8'd0);
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         chk($sformatf("post-abort fall%0d byte_done", i), {7'd0, byte_done}, 8'd0);
         chk($sformatf("post-abort fall%0d sda", i), {7'd0, sda_out}, 8'd1);
      end

      // 0xFF after the abort transmits normally; abort in ACK_HOLD keeps ack_received.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      chk("ff msb", {7'd0, sda_out}, 8'd1);
      send_bits(8'hFF, 0, 7, "ff");
      sdi = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      sdi = 1'b1;
      chk("ff ack_done", {7'd0, ack_done}, 8'd1);
      chk("ff ack_received", {7'd0, ack_received}, 8'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      chk("hold-abort byte_done", {7'd0, byte_done}, 8'd0);
      chk("hold-abort busy", {7'd0, tx_busy}, 8'd0);
      chk("hold-abort ack_received", {7'd0, ack_received}, 8'd1);

      // tx_enable dropping mid-byte behaves like abort.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h7E);
      chk("7e msb", {7'd0, sda_out}, 8'd0);
      en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("txen-off sda", {7'd0, sda_out}, 8'd1);
      chk("txen-off busy", {7'd0, tx_busy}, 8'd0);
      en = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef I2C_SLAVE_TX_STRETCH_EN
      // Stretching: hold SCL after an ACK until the next load, then async reset in WAIT_LOAD.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
      send_bits(8'h3C, 0, 7, "st");
      ack_phase(1'b0, 1'b1, 1'b1, "st");
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         chk($sformatf("st wait%0d scl_hold", i), {7'd0, scl_hold}, 8'd1);
         chk($sformatf("st wait%0d sda", i), {7'd0, sda_out}, 8'd1);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
      chk("st load scl_hold", {7'd0, scl_hold}, 8'd0);
      chk("st load msb", {7'd0, sda_out}, 8'd1);
      send_bits(8'h81, 0, 7, "st81");
      ack_phase(1'b0, 1'b1, 1'b1, "st81");
      chk("st81 scl_hold", {7'd0, scl_hold}, 8'd1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst sda_out", {7'd0, sda_out}, 8'd1);
      chk("arst tx_busy", {7'd0, tx_busy}, 8'd0);
      chk("arst ack_done", {7'd0, ack_done}, 8'd0);
      chk("arst ack_received", {7'd0, ack_received}, 8'd0);
      chk("arst byte_done", {7'd0, byte_done}, 8'd0);
      chk("arst scl_hold", {7'd0, scl_hold}, 8'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_stp_sr_tx_ctrl
